// File: rtl/pico_alu_seq.sv
// rtl/pico_alu_seq.sv - fixed-point accumulator ALU with a sequential shift-add multiplier
module pico_alu_seq #(
    parameter int W    = 8,
    parameter int FRAC = 3,
    parameter int SAT  = 1
) (
    input  logic         Clock,
    input  logic         nReset,
    input  logic         Clear,
    input  logic         Start,
    input  logic [1:0]   Op,
    input  logic         SelSW,
    input  logic         SelImm,
    input  logic [W-1:0] Imm,
    input  logic [W-1:0] RegData,
    input  logic [W-1:0] SW,
    output logic         Busy,
    output logic         Done,
    output logic [W-1:0] ACC,
    output logic         Zero,
    output logic         Neg,
    output logic         Ovf
);
    localparam int XW = 2 * W + 1;
    localparam int CW = $clog2(W);
    localparam logic signed [XW-1:0] SMAX = XW'((1 << (W - 1)) - 1);
    localparam logic signed [XW-1:0] SMIN = ~SMAX;

    typedef enum logic [1:0] {IDLE, MULT, WRITE} state_t;
    state_t state_q, state_d;

    logic [W-1:0]          b_sel, acc_src, b_q, acc_q, mplier, wr_val;
    logic [1:0]            op_q;
    logic                  pend, armed, accept, wr_en, wr_ovf;
    logic [CW-1:0]         cnt;
    logic signed [2*W-1:0] prod, mcand, psh;
    logic signed [XW-1:0]  res;

    assign b_sel  = SelSW ? SW : (SelImm ? Imm : RegData);
    assign Busy   = (state_q != IDLE);
    assign accept = Start & ~Busy & ~Clear & armed;
    assign wr_en  = pend | (state_q == WRITE);
    // A request accepted while a PASS/ADD write is pending must see the value being written.
    assign acc_src = pend ? wr_val : ACC;
    assign Zero   = (ACC == '0);
    assign Neg    = ACC[W-1];

    always_comb begin
        psh = prod >>> FRAC;
        case (op_q)
            2'b00:   res = {{(W+1){b_q[W-1]}}, b_q};
            2'b01:   res = {{(W+1){acc_q[W-1]}}, acc_q} + {{(W+1){b_q[W-1]}}, b_q};
            2'b10:   res = {psh[2*W-1], psh};
            default: res = {{(W+1){acc_q[W-1]}}, acc_q} + {psh[2*W-1], psh};
        endcase
        wr_ovf = (res > SMAX) || (res < SMIN);
        if (SAT != 0 && wr_ovf)
            wr_val = res[XW-1] ? SMIN[W-1:0] : SMAX[W-1:0];
        else
            wr_val = res[W-1:0];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && Op[1]) state_d = MULT;
            MULT:    if (cnt == CW'(W - 1)) state_d = WRITE;
            default: state_d = IDLE;
        endcase
        if (Clear) state_d = IDLE;
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            ACC    <= '0;
            Ovf    <= 1'b0;
            Done   <= 1'b0;
            pend   <= 1'b0;
            armed  <= 1'b0;
            op_q   <= 2'b00;
            b_q    <= '0;
            acc_q  <= '0;
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            armed <= 1'b1;
            Done  <= 1'b0;
            pend  <= 1'b0;
            if (Clear) begin
                ACC <= '0;
                Ovf <= 1'b0;
            end else begin
                if (wr_en) begin
                    ACC  <= wr_val;
                    Ovf  <= wr_ovf;
                    Done <= 1'b1;
                end
                if (accept) begin
                    op_q  <= Op;
                    b_q   <= b_sel;
                    acc_q <= acc_src;
                    pend  <= ~Op[1];
                    if (Op[1]) begin
                        mcand  <= Op[0] ? {{W{b_sel[W-1]}}, b_sel} : {{W{acc_src[W-1]}}, acc_src};
                        mplier <= Op[0] ? Imm : b_sel;
                        prod   <= '0;
                        cnt    <= '0;
                    end
                end else if (state_q == MULT) begin
                    // The multiplier MSB carries negative weight in two's complement.
                    if (mplier[0])
                        prod <= (cnt == CW'(W - 1)) ? prod - mcand : prod + mcand;
                    mcand  <= mcand <<< 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_pico_alu_seq.sv
// tb/tb_pico_alu_seq.sv - scoreboard bench for pico_alu_seq with SAT=1 and SAT=0 instances
module tb_pico_alu_seq;
    localparam logic [1:0] PASS = 2'b00, ADD = 2'b01, MUL = 2'b10, MAC = 2'b11;

    logic       Clock, nReset, Clear, Start, SelSW, SelImm;
    logic [1:0] Op;
    logic [7:0] Imm, RegData, SW;
    logic       Busy, Done, Zero, Neg, Ovf;
    logic [7:0] ACC;
    logic       Busy0, Done0, Zero0, Neg0, Ovf0;
    logic [7:0] ACC0;

    typedef struct {
        logic [7:0] acc;
        logic       ovf;
        logic       chk0;
        logic [7:0] acc0;
        logic       ovf0;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    pico_alu_seq #(.W(8), .FRAC(3), .SAT(1)) dut (
        .Clock(Clock), .nReset(nReset), .Clear(Clear), .Start(Start), .Op(Op),
        .SelSW(SelSW), .SelImm(SelImm), .Imm(Imm), .RegData(RegData), .SW(SW),
        .Busy(Busy), .Done(Done), .ACC(ACC), .Zero(Zero), .Neg(Neg), .Ovf(Ovf)
    );

    pico_alu_seq #(.W(8), .FRAC(3), .SAT(0)) dut0 (
        .Clock(Clock), .nReset(nReset), .Clear(Clear), .Start(Start), .Op(Op),
        .SelSW(SelSW), .SelImm(SelImm), .Imm(Imm), .RegData(RegData), .SW(SW),
        .Busy(Busy0), .Done(Done0), .ACC(ACC0), .Zero(Zero0), .Neg(Neg0), .Ovf(Ovf0)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] acc, input logic ovf);
        exp_t e;
        e.acc = acc; e.ovf = ovf; e.chk0 = 1'b0; e.acc0 = 8'h00; e.ovf0 = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk2(input logic [7:0] acc, input logic ovf,
                                 input logic [7:0] acc0, input logic ovf0);
        exp_t e;
        e.acc = acc; e.ovf = ovf; e.chk0 = 1'b1; e.acc0 = acc0; e.ovf0 = ovf0;
        return e;
    endfunction

    // Monitor: every Done pulse consumes one expected write.
    always @(negedge Clock) begin
        if (Done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("acc", int'(ACC), int'(e.acc));
                check("ovf", int'(Ovf), int'(e.ovf));
                check("zero", int'(Zero), int'(e.acc == 8'h00));
                check("neg", int'(Neg), int'(e.acc[7]));
                if (e.chk0) begin
                    check("sat0_done", int'(Done0), 1);
                    check("sat0_acc", int'(ACC0), int'(e.acc0));
                    check("sat0_ovf", int'(Ovf0), int'(e.ovf0));
                    check("sat0_zero", int'(Zero0), int'(e.acc0 == 8'h00));
                    check("sat0_neg", int'(Neg0), int'(e.acc0[7]));
                    check("sat0_busy", int'(Busy0), 0);
                end
            end
        end
    end

    // Call at a negedge; returns 1 time unit after the accepting edge, operands scrambled.
    task automatic issue(input logic [1:0] op, input logic selsw, input logic selimm,
                         input logic [7:0] imm, input logic [7:0] rd, input logic [7:0] sw);
        Op = op; SelSW = selsw; SelImm = selimm; Imm = imm; RegData = rd; SW = sw;
        Start = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0; Op = MAC; SelSW = 1'b0; SelImm = 1'b0;
        Imm = 8'h3C; RegData = 8'hA5; SW = 8'h5A;
    endtask

    task automatic wait_done(input int lat_exp, input int busy_exp, input int glitch);
        int n = 0;
        int bc = 0;
        do begin
            @(negedge Clock);
            n++;
            if (Busy) bc++;
            Start = (n == glitch);
        end while (!Done && n < 40);
        Start = 1'b0;
        check("latency", n - 1, lat_exp);
        check("busy_cycles", bc, busy_exp);
    endtask

    task automatic run(input logic [1:0] op, input logic selsw, input logic selimm,
                       input logic [7:0] imm, input logic [7:0] rd, input logic [7:0] sw,
                       input exp_t e, input int lat, input int busy, input int glitch);
        q.push_back(e);
        issue(op, selsw, selimm, imm, rd, sw);
        wait_done(lat, busy, glitch);
    endtask

    initial begin
        nReset = 1'b0; Clear = 1'b0; Start = 1'b0; Op = PASS;
        SelSW = 1'b0; SelImm = 1'b0; Imm = 8'h00; RegData = 8'h00; SW = 8'h00;
        repeat (2) @(negedge Clock);
        nReset = 1'b1;
        @(negedge Clock);
        check("rst_acc", int'(ACC), 0);
        check("rst_zero", int'(Zero), 1);
        check("rst_neg", int'(Neg), 0);
        check("rst_busy", int'(Busy), 0);
        check("rst_done", int'(Done), 0);
        check("rst_ovf", int'(Ovf), 0);

        run(PASS, 0, 1, 8'h05, 8'h00, 8'h00, mk2(8'h05, 0, 8'h05, 0), 1, 0, 0);
        run(PASS, 0, 1, 8'h64, 8'h00, 8'h00, mk2(8'h64, 0, 8'h64, 0), 1, 0, 0);
        run(ADD,  0, 0, 8'h00, 8'h64, 8'h00, mk2(8'h7F, 1, 8'hC8, 1), 1, 0, 0);
        run(PASS, 1, 1, 8'h77, 8'h00, 8'h10, mk(8'h10, 0), 1, 0, 0);
        run(MUL,  0, 0, 8'h00, 8'h18, 8'h00, mk(8'h30, 0), 9, 9, 3);
        run(PASS, 0, 1, 8'h80, 8'h00, 8'h00, mk(8'h80, 0), 1, 0, 0);
        run(MUL,  1, 0, 8'h00, 8'h00, 8'h80, mk(8'h7F, 1), 9, 9, 0);
        run(PASS, 0, 1, 8'h80, 8'h00, 8'h00, mk(8'h80, 0), 1, 0, 0);
        run(MUL,  0, 0, 8'h00, 8'h7F, 8'h00, mk(8'h80, 1), 9, 9, 0);
        run(PASS, 0, 1, 8'hFD, 8'h00, 8'h00, mk(8'hFD, 0), 1, 0, 0);
        run(MUL,  0, 1, 8'h05, 8'h00, 8'h00, mk(8'hFE, 0), 9, 9, 0);
        run(PASS, 0, 1, 8'h10, 8'h00, 8'h00, mk(8'h10, 0), 1, 0, 0);
        run(MAC,  0, 0, 8'h04, 8'hF8, 8'h00, mk(8'h0C, 0), 9, 9, 0);
        run(PASS, 0, 1, 8'h7F, 8'h00, 8'h00, mk(8'h7F, 0), 1, 0, 0);
        run(MAC,  1, 0, 8'h10, 8'h00, 8'h40, mk(8'h7F, 1), 9, 9, 0);

        // Clear sampled on the edge ending the 4th MULT cycle; no write may follow.
        issue(MUL, 0, 0, 8'h00, 8'h18, 8'h00);
        repeat (4) @(negedge Clock);
        Clear = 1'b1;
        @(negedge Clock);
        Clear = 1'b0;
        check("clr_acc", int'(ACC), 0);
        check("clr_busy", int'(Busy), 0);
        check("clr_ovf", int'(Ovf), 0);
        check("clr_zero", int'(Zero), 1);
        repeat (12) @(negedge Clock);
        run(PASS, 0, 1, 8'h01, 8'h00, 8'h00, mk(8'h01, 0), 1, 0, 0);
        run(ADD,  0, 0, 8'h00, 8'h7F, 8'h00, mk(8'h7F, 1), 1, 0, 0);

        // Asynchronous reset between edges in the middle of a multiply.
        issue(MUL, 0, 0, 8'h00, 8'h02, 8'h00);
        repeat (3) @(negedge Clock);
        #2 nReset = 1'b0;
        #1;
        check("arst_acc", int'(ACC), 0);
        check("arst_busy", int'(Busy), 0);
        check("arst_done", int'(Done), 0);
        check("arst_ovf", int'(Ovf), 0);
        check("arst_zero", int'(Zero), 1);
        @(negedge Clock);
        nReset = 1'b1;
        Op = PASS; SelSW = 1'b0; SelImm = 1'b1; Imm = 8'h33; Start = 1'b1;
        @(posedge Clock);
        #1 Start = 1'b0;
        repeat (3) @(negedge Clock);
        check("first_edge_ignored", int'(ACC), 0);
        run(PASS, 0, 1, 8'h01, 8'h00, 8'h00, mk(8'h01, 0), 1, 0, 0);

        repeat (3) @(negedge Clock);
        check("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pico_alu_seq.md
PICO_ALU_SEQ -- requirements
Module: pico_alu_seq

Interface
REQ-001 SHALL have parameter W, default 8: datapath/accumulator width in bits, W >= 4.
REQ-002 SHALL have parameter FRAC, default 3: fixed-point fraction bits; product is arithmetically shifted right by FRAC, with 0 <= FRAC < W.
REQ-003 SHALL have parameter SAT, default 1: 1 = saturating results, 0 = wrap-around results.
REQ-004 SHALL have ports (name  direction  width  meaning), in this order:
  Clock    in   1  rising-edge clock
  nReset   in   1  asynchronous, active-low reset
  Clear    in   1  synchronous clear/abort
  Start    in   1  operation request
  Op       in   2  00 PASS, 01 ADD, 10 MUL, 11 MAC
  SelSW    in   1  operand B = SW
  SelImm   in   1  operand B = Imm when SelSW = 0
  Imm      in   W  sign-extended immediate
  RegData  in   W  register-file data
  SW       in   W  switch input
  Busy     out  1  multi-cycle operation in progress
  Done     out  1  one-cycle pulse on ACC write
  ACC      out  W  accumulator
  Zero     out  1  ACC == 0
  Neg      out  1  ACC[W-1]
  Ovf      out  1  last write overflowed

Function
REQ-005 SHALL select operand B as follows: SelSW=1 gives SW; otherwise SelImm=1 gives Imm; otherwise RegData.
REQ-006 SHALL accept a request on a rising edge where Start=1, Busy=0 and Clear=0, capturing Op, B, Imm and ACC at that edge.
REQ-007 SHALL ignore Start while Busy=1; captured operands SHALL NOT change until the operation completes.
REQ-008 SHALL perform PASS (ACC<=B) and ADD (ACC<=ACC+B) in one cycle, writing ACC and pulsing Done on the edge after acceptance; Busy SHALL stay 0 for these operations.
REQ-009 SHALL perform MUL as ACC <= (ACC*B) >>> FRAC.
REQ-010 SHALL perform MAC as ACC <= ACC + ((B*Imm) >>> FRAC).
REQ-011 SHALL compute MUL and MAC using a sequential signed shift-add multiplier of exactly W iteration cycles.
REQ-012 SHALL implement an FSM with states IDLE, MULT and WRITE: IDLE -> MULT on an accepted MUL/MAC; MULT -> WRITE after W iterations; WRITE -> IDLE after one cycle.
REQ-013 SHALL hold Busy=1 in MULT and WRITE, and SHALL update ACC and pulse Done on the (W+1)th rising edge after the accepting edge.
REQ-014 SHALL accept a new Start on the cycle that Done=1, provided Busy=0.
REQ-015 SHALL treat all arithmetic as signed two's complement, SHALL form the full 2W-bit product before shifting, and SHALL compute the MAC sum at W+1 bits.
REQ-016 SHALL, when SAT=1, clamp out-of-range results to 2^(W-1)-1 or -2^(W-1); when SAT=0, it SHALL keep the low W bits.
REQ-017 SHALL set Ovf on every ACC write to 1 if the exact result was outside the W-bit signed range (for either SAT value), else 0; Ovf SHALL hold between writes.
REQ-018 SHALL drive Zero and Neg combinationally from ACC.
REQ-019 SHALL give Clear=1 priority over Start: on that edge ACC<=0, Ovf<=0, FSM<=IDLE, Busy<=0, with no Done pulse, including when a multiply is in progress.
REQ-020 SHALL pulse Done for exactly one cycle per completed operation.

Reset
REQ-021 SHALL, while nReset=0, asynchronously force ACC=0, Ovf=0, Busy=0, Done=0 and FSM=IDLE, aborting any operation in progress.
REQ-022 SHALL accept no request on the first rising edge at which nReset is sampled high after deassertion.

Verification (W=8, FRAC=3, SAT=1 unless stated)
REQ-023 SHALL cover: reset, then PASS with SelImm=1, Imm=0x05 -> ACC=0x05 and Done=1 one cycle later; Zero=0, Neg=0, Busy never 1.
REQ-024 SHALL cover: ACC=100, ADD with B=100 -> ACC=127, Ovf=1; the same stimulus with SAT=0 -> ACC=0xC8, Ovf=1.
REQ-025 SHALL cover: ACC=16, MUL with B=24 -> ACC=48 and Done on the 9th edge after acceptance; Busy=1 for 9 cycles; a Start pulse mid-operation is ignored.
REQ-026 SHALL cover: ACC=-128, MUL with B=-128 -> ACC=127, Ovf=1; ACC=0x10, MAC with RegData=-8, Imm=4 -> ACC=0x0C, Ovf=0.
REQ-027 SHALL cover: Clear on the 4th MULT cycle -> ACC=0, Busy=0, no Done pulse; next PASS of 0x01 -> ACC=0x01.
REQ-028 SHALL cover: nReset pulled low mid-MUL between clock edges -> all outputs reset immediately with no Done pulse; normal operation resumes after release.
